// File: rtl/rv32i_mem_arbiter_if.sv
// Bundle of the fetch, load/store and memory-port signals around the rv32i memory arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters + memory).
interface rv32i_mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [DW-1:0]   i_rdata;

    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [DW/8-1:0] mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ready;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ready, mem_rvalid, mem_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ready, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// Single-port memory arbiter: fetch vs load/store, D-side priority with a starvation guard.
// One transaction in flight; the winning request is registered and driven until accepted.
module rv32i_mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rv32i_mem_arbiter_if.slave   bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t          r_state;
    logic [SW-1:0]   r_streak;
    logic            r_owner_d;
    logic            r_i_gnt;
    logic            r_d_gnt;
    logic            r_mem_req;
    logic            r_mem_we;
    logic [DW/8-1:0] r_mem_be;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;

    logic            w_pick_d;
    logic            w_resp;

    // D wins any contention except when fetch has lost STARVE_LIMIT times in a row.
    assign w_pick_d = bus.d_req && (!bus.i_req || (r_streak != LIMIT));
    assign w_resp   = (r_state == WAIT) && bus.mem_rvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_streak    <= '0;
            r_owner_d   <= 1'b0;
            r_i_gnt     <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_i_gnt <= 1'b0;
            r_d_gnt <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        r_state   <= ISSUE;
                        r_mem_req <= 1'b1;
                        r_owner_d <= w_pick_d;
                        if (w_pick_d) begin
                            r_d_gnt     <= 1'b1;
                            r_mem_we    <= bus.d_we;
                            r_mem_be    <= bus.d_be;
                            r_mem_addr  <= bus.d_addr;
                            r_mem_wdata <= bus.d_wdata;
                            if (!bus.i_req)
                                r_streak <= '0;
                            else if (r_streak != LIMIT)
                                r_streak <= r_streak + 1'b1;
                        end else begin
                            r_i_gnt     <= 1'b1;
                            r_mem_we    <= 1'b0;
                            r_mem_be    <= '1;
                            r_mem_addr  <= bus.i_addr;
                            r_mem_wdata <= '0;
                            r_streak    <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (bus.mem_ready) begin
                        r_mem_req <= 1'b0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_rvalid)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.i_gnt     = r_i_gnt;
    assign bus.d_gnt     = r_d_gnt;
    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_be    = r_mem_be;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;

    // Response is forwarded in the same cycle it arrives; data is unqualified pass-through.
    assign bus.i_rvalid  = w_resp && !r_owner_d;
    assign bus.d_rvalid  = w_resp && r_owner_d;
    assign bus.i_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = bus.mem_rdata;
endmodule
